i2c_target_regs: RTL and testbench

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing four 8-bit registers behind an auto-incrementing 2-bit pointer.
// SCL/SDA are oversampled by clk; all bus timing is derived from synchronized edges.
module i2c_target_regs #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [31:0] reg_data,
  output logic        wr_pulse,
  output logic [1:0]  wr_index,
  output logic        busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned N_REGS = 4;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    PTR,
    ACK_PTR,
    WDATA,
    ACK_W,
    RDATA,
    WAIT_MACK,
    IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, sda_rise, sda_fall;
  logic                   start_det, stop_det;

  state_t                           state_q, state_n;
  logic [CNT_W-1:0]                 cnt_q, cnt_n;
  logic [BYTE_W-1:0]                shift_q, shift_n;
  logic [PTR_W-1:0]                 ptr_q, ptr_n;
  logic [N_REGS-1:0][BYTE_W-1:0]    regs_q, regs_n;
  logic                             rw_q, rw_n;
  logic                             sda_oe_q, sda_oe_n;
  logic                             busy_q, busy_n;
  logic                             wr_pulse_q, wr_pulse_n;
  logic [PTR_W-1:0]                 wr_index_q, wr_index_n;

  logic [BYTE_W-1:0]                byte_in;
  logic [BYTE_W-1:0]                rd_byte;
  logic                             byte_done;

  // Synchronizers reset to 1 so an idle bus produces no edges after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign sda_rise  = sda_s & ~sda_d;
  assign sda_fall  = ~sda_s & sda_d;
  assign start_det = sda_fall & scl_s & scl_d;
  assign stop_det  = sda_rise & scl_s & scl_d;

  assign byte_in   = {shift_q[BYTE_W-2:0], sda_s};
  assign byte_done = scl_rise && (cnt_q == CNT_W'(BYTE_W - 1));
  assign rd_byte   = regs_q[ptr_q];

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      regs_q     <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      shift_q    <= shift_n;
      ptr_q      <= ptr_n;
      regs_q     <= regs_n;
      rw_q       <= rw_n;
      sda_oe_q   <= sda_oe_n;
      busy_q     <= busy_n;
      wr_pulse_q <= wr_pulse_n;
      wr_index_q <= wr_index_n;
    end
  end

  // Next-state and output logic; START/STOP override every state
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    shift_n    = shift_q;
    ptr_n      = ptr_q;
    regs_n     = regs_q;
    rw_n       = rw_q;
    sda_oe_n   = sda_oe_q;
    busy_n     = busy_q;
    wr_pulse_n = 1'b0;
    wr_index_n = wr_index_q;

    if (start_det) begin
      state_n  = ADDR;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_n = byte_in;
            cnt_n   = cnt_q + CNT_W'(1);
          end
          if (byte_done) begin
            cnt_n = '0;
            case (state_q)
              ADDR: begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state_n = ACK_ADDR;
                  busy_n  = 1'b1;
                  rw_n    = byte_in[0];
                end else begin
                  state_n = IGNORE;
                end
              end
              PTR: begin
                ptr_n   = byte_in[PTR_W-1:0];
                state_n = ACK_PTR;
              end
              default: begin
                regs_n[ptr_q] = byte_in;
                wr_pulse_n    = 1'b1;
                wr_index_n    = ptr_q;
                ptr_n         = ptr_q + PTR_W'(1);
                state_n       = ACK_W;
              end
            endcase
          end
        end

        // First SCL fall drives the ACK, the next one releases it
        ACK_ADDR, ACK_PTR, ACK_W: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n = 1'b0;
              cnt_n    = '0;
              if (state_q == ACK_ADDR && rw_q) begin
                state_n  = RDATA;
                sda_oe_n = ~rd_byte[BYTE_W-1];
                shift_n  = {rd_byte[BYTE_W-2:0], 1'b0};
              end else if (state_q == ACK_ADDR) begin
                state_n = PTR;
              end else begin
                state_n = WDATA;
              end
            end
          end
        end

        // shift_q[7] holds the next bit to present on each SCL fall
        RDATA: begin
          if (scl_rise) begin
            cnt_n = cnt_q + CNT_W'(1);
          end else if (scl_fall) begin
            if (cnt_q == CNT_W'(BYTE_W)) begin
              sda_oe_n = 1'b0;
              cnt_n    = '0;
              state_n  = WAIT_MACK;
            end else begin
              sda_oe_n = ~shift_q[BYTE_W-1];
              shift_n  = {shift_q[BYTE_W-2:0], 1'b0};
            end
          end
        end

        // cnt_q==1 marks a received master ACK awaiting the next SCL fall
        WAIT_MACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_n = ptr_q + PTR_W'(1);
              cnt_n = CNT_W'(1);
            end else begin
              state_n = IGNORE;
            end
          end else if (scl_fall && cnt_q == CNT_W'(1)) begin
            state_n  = RDATA;
            cnt_n    = '0;
            sda_oe_n = ~rd_byte[BYTE_W-1];
            shift_n  = {rd_byte[BYTE_W-2:0], 1'b0};
          end
        end

        IDLE, IGNORE: begin
          sda_oe_n = 1'b0;
        end

        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign reg_data = regs_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_index = wr_index_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed I2C master stimulus for i2c_target_regs with queued expectations
// checked by independent bus and register-write monitors.
module tb_i2c_target_regs;

  localparam int unsigned Q = 100;  // quarter SCL period in ns

  typedef struct packed {
    logic [1:0] kind;   // 0: ACK bit seen by master, 1: byte read back
    logic [7:0] val;
  } bus_item_t;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] val;
  } wr_item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        scl_in, sda_in;
  logic        sda_oe;
  logic [31:0] reg_data;
  logic        wr_pulse;
  logic [1:0]  wr_index;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_seen  = 0;
  logic oe_seen = 1'b0;

  bus_item_t exp_q[$];
  bus_item_t obs_q[$];
  wr_item_t  wr_q[$];

  i2c_target_regs #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .reg_data (reg_data),
    .wr_pulse (wr_pulse),
    .wr_index (wr_index),
    .busy     (busy)
  );

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bus scoreboard: pairs each observed ACK/read byte with its queued expectation
  initial forever begin
    bus_item_t o, e;
    @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL bus_unexpected: got %h expected nothing", o);
      end else begin
        e = exp_q.pop_front();
        check(e.kind == 2'd0 ? "ack" : "read_byte", 32'(o), 32'(e));
      end
    end
  end

  // Write monitor: every wr_pulse must match the next queued register write
  initial begin
    logic wr_prev = 1'b0;
    forever begin
      wr_item_t e;
      @(negedge clk);
      if (wr_pulse) begin
        wr_seen++;
        check("wr_pulse_width", 32'(wr_prev), 32'd0);
        if (wr_q.size() == 0) begin
          n_checks++;
          $display("FAIL wr_unexpected: got index %0d expected no write", wr_index);
        end else begin
          e = wr_q.pop_front();
          check("wr_index", 32'(wr_index), 32'(e.idx));
          check("wr_reg", 32'(reg_data[int'(e.idx)*8 +: 8]), 32'(e.val));
        end
      end
      wr_prev = wr_pulse;
    end
  end

  initial forever begin
    @(posedge clk);
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;
    #Q; scl_m = 1'b1;
    #Q; r = sda_in;
    #Q; scl_m = 1'b0;
    #Q;
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b0;
    #Q; scl_m = 1'b0;
    #Q;
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b1;
    #Q; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack);
    logic r;
    exp_q.push_back('{kind: 2'd0, val: {7'd0, exp_ack}});
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    obs_q.push_back('{kind: 2'd0, val: {7'd0, ~r}});
  endtask

  task automatic recv_byte(input logic [7:0] exp_d, input logic mack);
    logic r;
    logic [7:0] d;
    exp_q.push_back('{kind: 2'd1, val: exp_d});
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    obs_q.push_back('{kind: 2'd1, val: d});
    bit_xfer(~mack, r);
  endtask

  initial begin
    int w0;

    #20;
    check("rst_sda_oe",   32'(sda_oe),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check("rst_wr_index", 32'(wr_index), 32'd0);
    check("rst_reg_data", reg_data,      32'h0);
    #13 rst = 1'b0;
    #(4*Q);

    // Write 5A, C3 starting at pointer 1
    start_c();
    send_byte(8'hA0, 1'b1);
    check("busy_after_match", 32'(busy), 32'd1);
    send_byte(8'h01, 1'b1);
    wr_q.push_back('{idx: 2'd1, val: 8'h5A});
    send_byte(8'h5A, 1'b1);
    wr_q.push_back('{idx: 2'd2, val: 8'hC3});
    send_byte(8'hC3, 1'b1);
    stop_c();
    check("write_reg_data", reg_data, 32'h00C35A00);
    check("busy_after_stop", 32'(busy), 32'd0);

    // Repeated-start read of two bytes from pointer 1
    start_c();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h01, 1'b1);
    start_c();
    send_byte(8'hA1, 1'b1);
    recv_byte(8'h5A, 1'b1);
    recv_byte(8'hC3, 1'b0);
    check("sda_oe_after_nack", 32'(sda_oe), 32'd0);
    stop_c();

    // Address mismatch: bus untouched
    oe_seen = 1'b0;
    start_c();
    send_byte(8'hA2, 1'b0);
    check("busy_mismatch", 32'(busy), 32'd0);
    send_byte(8'h55, 1'b0);
    stop_c();
    check("oe_mismatch", 32'(oe_seen), 32'd0);
    check("regs_mismatch", reg_data, 32'h00C35A00);

    // Pointer wraps 3 -> 0
    start_c();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h03, 1'b1);
    wr_q.push_back('{idx: 2'd3, val: 8'h11});
    send_byte(8'h11, 1'b1);
    wr_q.push_back('{idx: 2'd0, val: 8'h22});
    send_byte(8'h22, 1'b1);
    stop_c();
    check("wrap_reg_data", reg_data, 32'h11C35A22);

    // Pointer persists across STOP (now 1)
    start_c();
    send_byte(8'hA1, 1'b1);
    recv_byte(8'h5A, 1'b0);
    stop_c();

    // STOP after 4 bits of a data byte discards it
    w0 = wr_seen;
    start_c();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h02, 1'b1);
    begin
      logic r;
      for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
    end
    stop_c();
    check("partial_no_write", 32'(wr_seen - w0), 32'd0);
    check("partial_regs", reg_data, 32'h11C35A22);
    check("partial_busy", 32'(busy), 32'd0);
    start_c();
    send_byte(8'hA1, 1'b1);
    recv_byte(8'hC3, 1'b0);
    stop_c();

    // Reset while the target drives a 0 read bit (reg0 = 22, MSB 0)
    start_c();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h00, 1'b1);
    start_c();
    send_byte(8'hA1, 1'b1);
    check("read_drives_zero", 32'(sda_oe), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_sda_oe",   32'(sda_oe),   32'd0);
    check("rst_mid_busy",     32'(busy),     32'd0);
    check("rst_mid_wr_pulse", 32'(wr_pulse), 32'd0);
    check("rst_mid_wr_index", 32'(wr_index), 32'd0);
    check("rst_mid_reg_data", reg_data,      32'h0);
    #20 rst = 1'b0;
    #(Q - 23);
    stop_c();
    check("post_rst_busy", 32'(busy), 32'd0);
    start_c();
    send_byte(8'hA1, 1'b1);
    recv_byte(8'h00, 1'b0);
    stop_c();

    repeat (50) @(negedge clk);
    check("bus_q_drained", 32'(exp_q.size()), 32'd0);
    check("wr_q_drained",  32'(wr_q.size()),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
